coo_aggregation: RTL and testbench

//  Aggregation stage of the GCN datapath, between the feature x weight transformation stage and the argmax stage.
//  - Takes the FEATURE_ROWS x WEIGHT_COLS transformed matrix (fm_wm_in).
//  - Streams the COO adjacency list from COO memory, one edge per clock.
//  - Produces agg_out = (A + I) * fm_wm: every node keeps its own row and adds the rows of its neighbours.
//  - agg_out is then consumed by the argmax stage.

---
 rtl/gcn_pkg.sv | 28 ++
 rtl/agg_row_adder.sv | 15 +
 rtl/coo_aggregation.sv | 111 +++++++++++
 tb/tb_coo_aggregation.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared types and defaults for the GCN aggregation datapath.
// Row/matrix layouts match the flat fm_wm/agg_out buses bit for bit.
package gcn_pkg;

    localparam int FEATURE_ROWS    = 6;
    localparam int WEIGHT_COLS     = 3;
    localparam int DOT_PROD_WIDTH  = 16;
    localparam int NUM_OF_NODES    = 6;
    localparam int COO_NUM_OF_COLS = 6;
    localparam int COO_BW          = $clog2(COO_NUM_OF_COLS);
    localparam int MAT_W           = FEATURE_ROWS * WEIGHT_COLS * DOT_PROD_WIDTH;

    typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;
    typedef row_t [FEATURE_ROWS-1:0] mat_t;
    typedef logic [COO_BW-1:0] node_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACCUM,
        DONE
    } agg_state_e;

    function automatic logic valid_node(node_idx_t idx);
        return (idx != '0) && (int'(idx) <= NUM_OF_NODES);
    endfunction

endpackage

// File: rtl/agg_row_adder.sv
// One row of parallel modulo-2^DOT_PROD_WIDTH adders.
// Carries out of each element are dropped on purpose (wrap-around).
module agg_row_adder
    import gcn_pkg::*;
(
    input  row_t i_a,
    input  row_t i_b,
    output row_t o_sum
);

    for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_col
        assign o_sum[c] = i_a[c] + i_b[c];
    end

endmodule

// File: rtl/coo_aggregation.sv
// Aggregation stage: agg_out = (A + I) * fm_wm, with A streamed from a
// COO edge list one edge per clock.
module coo_aggregation
    import gcn_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MAT_W-1:0]      fm_wm_in,
    input  logic [2*COO_BW-1:0]   coo_in,
    output logic [COO_BW-1:0]     coo_address,
    output logic [MAT_W-1:0]      agg_out,
    output logic                  done
);

    localparam node_idx_t LAST = node_idx_t'(COO_NUM_OF_COLS - 1);

    agg_state_e  r_state;
    node_idx_t   r_cnt;
    mat_t        r_agg;

    mat_t        w_fm;
    node_idx_t   w_src;
    node_idx_t   w_dst;
    logic        w_edge_ok;
    node_idx_t   w_si;
    node_idx_t   w_di;
    row_t        w_sum_src;
    row_t        w_sum_dst;
    logic [FEATURE_ROWS-1:0] w_we_src;
    logic [FEATURE_ROWS-1:0] w_we_dst;

    assign w_fm      = fm_wm_in;
    assign agg_out   = r_agg;
    assign w_src     = coo_in[COO_BW-1:0];
    assign w_dst     = coo_in[2*COO_BW-1:COO_BW];
    assign w_edge_ok = valid_node(w_src) && valid_node(w_dst);

    // Row indices are clamped to 0 for padding edges so selects stay in range.
    assign w_si = w_edge_ok ? node_idx_t'(w_src - 1'b1) : '0;
    assign w_di = w_edge_ok ? node_idx_t'(w_dst - 1'b1) : '0;

    // Addends come from fm_wm_in, so edge order never matters.
    agg_row_adder u_add_src (
        .i_a   (r_agg[w_si]),
        .i_b   (w_fm[w_di]),
        .o_sum (w_sum_src)
    );

    agg_row_adder u_add_dst (
        .i_a   (r_agg[w_di]),
        .i_b   (w_fm[w_si]),
        .o_sum (w_sum_dst)
    );

    always_comb begin
        w_we_src = '0;
        w_we_dst = '0;
        for (int r = 0; r < FEATURE_ROWS; r++) begin
            w_we_src[r] = w_edge_ok && (w_si == node_idx_t'(r));
            w_we_dst[r] = w_edge_ok && (w_si != w_di)
                          && (w_di == node_idx_t'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_agg       <= '0;
            coo_address <= '0;
            done        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) r_state <= LOAD;
                end
                LOAD: begin
                    r_agg       <= w_fm;
                    coo_address <= '0;
                    r_cnt       <= '0;
                    r_state     <= ACCUM;
                end
                ACCUM: begin
                    for (int r = 0; r < FEATURE_ROWS; r++) begin
                        if (w_we_src[r])
                            r_agg[r] <= w_sum_src;
                        else if (w_we_dst[r])
                            r_agg[r] <= w_sum_dst;
                    end
                    coo_address <= (r_cnt == LAST) ? LAST : node_idx_t'(r_cnt + 1'b1);
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= node_idx_t'(r_cnt + 1'b1);
                    end
                end
                DONE: begin
                    // done is shown for at least one cycle before start can retire it.
                    if (!done) begin
                        done <= 1'b1;
                    end else if (!start) begin
                        done    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coo_aggregation.sv
// Scoreboard bench for coo_aggregation: directed COO edge lists with
// hand-computed aggregated matrices, negedge-read COO memory model.
module tb_coo_aggregation;
    import gcn_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    mat_t                fm;
    logic [2*COO_BW-1:0] coo_in;
    node_idx_t           coo_address;
    mat_t                agg;
    logic                done;

    logic [2*COO_BW-1:0] mem [COO_NUM_OF_COLS];

    int   checks = 0;
    int   failures = 0;
    mat_t exp_q[$];
    mat_t ex;
    logic prev_done = 1'b0;

    coo_aggregation dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .fm_wm_in    (fm),
        .coo_in      (coo_in),
        .coo_address (coo_address),
        .agg_out     (agg),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) coo_in <= mem[coo_address];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        mat_t e;
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                for (int r = 0; r < FEATURE_ROWS; r++)
                    chk($sformatf("agg_row%0d", r + 1), 64'(agg[r]), 64'(e[r]));
            end
        end
        prev_done <= done;
    end

    function automatic logic [2*COO_BW-1:0] edg(input int s, input int d);
        return {node_idx_t'(d), node_idx_t'(s)};
    endfunction

    task automatic clr_edges();
        for (int k = 0; k < COO_NUM_OF_COLS; k++) mem[k] = '0;
    endtask

    task automatic base_fm();
        for (int r = 0; r < FEATURE_ROWS; r++)
            for (int c = 0; c < WEIGHT_COLS; c++)
                fm[r][c] = 16'(r * 16 + c + 1);
    endtask

    task automatic ones_fm();
        for (int r = 0; r < FEATURE_ROWS; r++)
            for (int c = 0; c < WEIGHT_COLS; c++)
                fm[r][c] = 16'd1;
    endtask

    task automatic ring_edges();
        mem[0] = edg(1, 2);
        mem[1] = edg(2, 3);
        mem[2] = edg(3, 4);
        mem[3] = edg(4, 5);
        mem[4] = edg(5, 6);
        mem[5] = edg(6, 1);
    endtask

    task automatic run(input bit drop);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 20);
        chk("latency", 64'(n), 64'd8);
        if (drop) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        clr_edges();
        base_fm();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_agg", 64'(agg[0]) | 64'(agg[5]), 64'd0);
        chk("rst_addr", 64'(coo_address), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: padding-only edge list leaves fm unchanged
        ex = fm;
        exp_q.push_back(ex);
        run(1);

        // 2: single edge (1,2)
        fm[0] = {16'd3, 16'd2, 16'd1};
        fm[1] = {16'd30, 16'd20, 16'd10};
        ex = fm;
        ex[0] = {16'd33, 16'd22, 16'd11};
        ex[1] = {16'd33, 16'd22, 16'd11};
        mem[0] = edg(1, 2);
        exp_q.push_back(ex);
        run(1);

        // 3: self loop (3,3) and out-of-range (7,2)
        clr_edges();
        base_fm();
        fm[2] = {16'd6, 16'd5, 16'd4};
        ex = fm;
        ex[2] = {16'd12, 16'd10, 16'd8};
        mem[2] = edg(3, 3);
        mem[4] = edg(7, 2);
        exp_q.push_back(ex);
        run(1);

        // 4: modulo wrap
        clr_edges();
        base_fm();
        fm[0] = {16'd0, 16'd0, 16'hFFFF};
        fm[1] = {16'd0, 16'd0, 16'h0002};
        ex = fm;
        ex[0] = {16'd0, 16'd0, 16'h0001};
        ex[1] = {16'd0, 16'd0, 16'h0001};
        mem[5] = edg(1, 2);
        exp_q.push_back(ex);
        run(1);

        // 5: full ring, every node has two neighbours
        ones_fm();
        ring_edges();
        for (int r = 0; r < FEATURE_ROWS; r++)
            ex[r] = {16'd3, 16'd3, 16'd3};
        exp_q.push_back(ex);
        run(1);

        // 6: reset in the middle of accumulation
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_agg", 64'(agg[0]) | 64'(agg[3]) | 64'(agg[5]), 64'd0);
        chk("abort_addr", 64'(coo_address), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        exp_q.push_back(ex);
        run(0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_done", 64'(done), 64'd1);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_fall", 64'(done), 64'd0);

        exp_q.push_back(ex);
        run(1);

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_runs actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
